mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch port (IF) and the data-access port (D, lw/sw).
- Sits between the CPU datapath (PC/fetch logic and MEM stage) and the memory model; it serialises their requests.
- Per-port req/ack handshake; req/ack handshake toward memory with variable latency.
- The CPU stalls its fetch and MEM stages while the corresponding ack is outstanding.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
if_req_i  in  1  fetch request; held with stable address until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetched instruction; valid in if_ack_o cycle, held until the next IF ack
if_ack_o  out  1  one-cycle completion pulse for IF
d_req_i  in  1  data request; held with stable addr/we/wdata until d_ack_o
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_rdata_o  out  DATA_W  read data; valid in d_ack_o cycle, held until the next D read ack
d_ack_o  out  1  one-cycle completion pulse for D
mem_req_o  out  1  memory request; held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address (registered)
mem_wdata_o  out  DATA_W  memory write data (registered)
mem_rdata_i  in  DATA_W  memory read data; valid when mem_ack_i=1
mem_ack_i  in  1  memory completion pulse; latency ≥1 cycle after mem_req_o rises
busy_o  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, d_ack_o, if_rdata_o, d_rdata_o, busy_o.
  - last_grant is set to D.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant that port.
  - Both req high: arbitration rule applies (see Optional Feature).
  - On grant: latch addr, and for D also we and wdata, into mem_*_o registers; set mem_req_o=1; go to BUSY_I or BUSY_D.
  - mem_req_o rises the cycle after the grant decision.
- BUSY_x:
  - mem_req_o stays 1 and mem_addr_o/we/wdata stay stable until mem_ack_i=1.
  - On mem_ack_i:
    - mem_req_o←0 and mem_we_o←0.
    - For an IF grant or a D read, capture mem_rdata_i into the granted port's rdata register.
    - Pulse that port's ack for exactly one cycle (the next cycle).
    - Go to RESP.
- RESP:
  - Ack is high in this cycle.
  - No new grant this cycle: the requester's req is still high and must not be re-granted.
  - Next state is IDLE unconditionally.
- Latency: req seen in IDLE at cycle T, memory acks at T+1+L (L ≥ 1 cycles after mem_req_o rises), port ack at T+2+L.
- Minimum occupancy is 4 cycles per transaction with L=1.
- D write: d_rdata_o is not updated; d_ack_o still pulses.
- mem_ack_i outside BUSY_x is ignored (stray ack, or an ack arriving after a mid-operation reset).
- A req dropped by a requester before its ack is a protocol violation; behaviour is undefined and is not checked.
- if_ack_o and d_ack_o are never high in the same cycle.
- last_grant updates to the granted port on every grant (used only by the round-robin option).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on conflict. When both reqs are high in IDLE, grant the port that is not last_grant. After reset, last_grant=D, so IF wins the first conflict.
- Undefined: fixed priority on conflict. D always wins, because the MEM stage is the older instruction. IF can starve while D requests are back-to-back. last_grant is still maintained but unused.

Test Plan:
- IF-only read, memory L=2, mem[0x40]=0x8C080004, if_req_i=1 with addr 0x40:
  - mem_req_o rises at T+1 with mem_addr_o=0x40, mem_we_o=0.
  - if_ack_o pulses at T+4; if_rdata_o=0x8C080004 from then on.
- D write then D read, addr 0x100, wdata 0xDEADBEEF:
  - Write: mem_we_o=1 and mem_wdata_o=0xDEADBEEF during BUSY_D; d_ack_o pulses; d_rdata_o is unchanged.
  - Read: d_rdata_o=0xDEADBEEF in the d_ack_o cycle.
- Simultaneous IF (0x44) and D read (0x200) held high, two transactions:
  - Without MEM_ARB_RR_EN: D is served first, then IF.
  - With MEM_ARB_RR_EN: IF first (last_grant=D after reset), then D.
  - The two acks are ≥4 cycles apart and never coincide.
- Back-to-back IF with req held high, addr changed to 0x48 in the ack cycle:
  - No grant in the RESP cycle.
  - Second mem_req_o has mem_addr_o=0x48 and rises 2 cycles after the first if_ack_o.
- rst_i=1 while in BUSY_D; memory later returns mem_ack_i:
  - Next cycle: busy_o=0, mem_req_o=0, state IDLE.
  - The late mem_ack_i produces no ack and no rdata change.
- With MEM_ARB_RR_EN, both reqs held high for 6 transactions:
  - Grants alternate IF, D, IF, D, IF, D.
  - Without the macro: 6 consecutive D grants while d_req_i is kept high.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises the CPU instruction-fetch port (IF) and the data port
//            (D, lw/sw) onto one single-ported memory with a req/ack
//            handshake of variable latency.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            if_req_i/if_addr_i    - fetch request and address
//            if_rdata_o/if_ack_o   - fetched word and one-cycle completion
//            d_req_i/d_we_i/d_addr_i/d_wdata_i - data request
//            d_rdata_o/d_ack_o     - read data and one-cycle completion
//            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - memory request side
//            mem_rdata_i/mem_ack_i - memory response
//            busy_o                - high whenever a transaction is in flight
// Options  : MEM_ARB_RR_EN - round-robin on conflict (default: D wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic w_grant_vld;
  logic w_grant_port;
  logic w_conflict_port;
  logic w_mem_done;

  // Winner when both ports request in the same IDLE cycle.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    w_conflict_port = (last_grant_q == PORT_D) ? PORT_IF : PORT_D;
`else
    // The MEM stage holds the older instruction, so data always wins.
    w_conflict_port = PORT_D;
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    w_grant_vld  = 1'b0;
    w_grant_port = PORT_D;
    w_mem_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req_i || d_req_i) begin
          w_grant_vld  = 1'b1;
          if (if_req_i && d_req_i) begin
            w_grant_port = w_conflict_port;
          end else begin
            w_grant_port = d_req_i ? PORT_D : PORT_IF;
          end
          last_grant_d = w_grant_port;
          state_d      = (w_grant_port == PORT_D) ? S_BUSY_D : S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        // Acks are only honoured here; a stray ack in IDLE/RESP is dropped.
        if (mem_ack_i) begin
          w_mem_done = 1'b1;
          state_d    = S_RESP;
        end
      end
      // RESP never grants: the finishing requester still holds its req.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches and response data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (w_grant_vld) begin
        if (w_grant_port == PORT_D) begin
          mem_addr_q  <= d_addr_i;
          mem_we_q    <= d_we_i;
          mem_wdata_q <= d_wdata_i;
        end else begin
          mem_addr_q  <= if_addr_i;
          mem_we_q    <= 1'b0;
        end
      end
      if (w_mem_done) begin
        mem_we_q <= 1'b0;
        if (state_q == S_BUSY_I) begin
          if_rdata_q <= mem_rdata_i;
        end else if (!mem_we_q) begin
          d_rdata_q <= mem_rdata_i;
        end
      end
    end
  end

  // Output logic; in RESP last_grant_q names the port being completed.
  always_comb begin
    mem_req_o = 1'b0;
    busy_o    = 1'b0;
    if_ack_o  = 1'b0;
    d_ack_o   = 1'b0;
    case (state_q)
      S_BUSY_I, S_BUSY_D: begin
        mem_req_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_RESP: begin
        busy_o   = 1'b1;
        if_ack_o = (last_grant_q == PORT_IF);
        d_ack_o  = (last_grant_q == PORT_D);
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Random requesters and a
//            variable-latency memory drive the DUT; a transaction-level
//            reference model predicts grants, timing and returned data.
// Options  : MEM_ARB_RR_EN - expectations follow the round-robin rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int M_OFF   = 0;
  localparam int M_RAND  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HOLD  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busy_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] w;
    w = 4'($urandom_range(15, 0));
    return {26'd0, w, 2'b00};
  endfunction

  // Stimulus controls
  int          if_mode = M_OFF;
  int          d_mode  = M_OFF;
  logic [31:0] if_hold_addr = 32'h0;
  logic [31:0] d_hold_addr  = 32'h0;
  logic        d_hold_we    = 1'b0;
  logic [31:0] d_hold_wdata = 32'h0;
  int          lat_min = 1;
  int          lat_max = 3;
  bit          stray_en = 1'b0;

  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];

  // Memory: ack L>=1 cycles after it first sees mem_req_o, plus stray acks.
  initial begin
    bit active;
    int cnt;
    active = 1'b0;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (active) begin
        cnt--;
        if (cnt == 0) begin
          active = 1'b0;
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            phys_mem[mem_addr_o[5:2]] = mem_wdata_o;
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = phys_mem[mem_addr_o[5:2]];
          end
        end
      end else if (mem_req_o) begin
        active = 1'b1;
        cnt = $urandom_range(lat_max, lat_min);
      end else if (stray_en && $urandom_range(7, 0) == 0) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = $urandom;
      end
    end
  end

  // IF requester
  initial begin
    if_req_i = 1'b0;
    if_addr_i = '0;
    forever begin
      @(posedge clk_i); #1;
      case (if_mode)
        M_OFF:   if_req_i = 1'b0;
        M_HOLD:  begin if_req_i = 1'b1; if_addr_i = if_hold_addr; end
        M_DRAIN: if (if_ack_o) if_req_i = 1'b0;
        default: begin
          if (if_req_i) begin
            if (if_ack_o) begin
              if ($urandom_range(1, 0) == 1) if_addr_i = rand_addr();
              else if_req_i = 1'b0;
            end
          end else if ($urandom_range(2, 0) == 0) begin
            if_req_i = 1'b1;
            if_addr_i = rand_addr();
          end
        end
      endcase
    end
  end

  // D requester
  initial begin
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    d_addr_i = '0;
    d_wdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      case (d_mode)
        M_OFF:   d_req_i = 1'b0;
        M_HOLD:  begin
          d_req_i = 1'b1; d_addr_i = d_hold_addr; d_we_i = d_hold_we; d_wdata_i = d_hold_wdata;
        end
        M_DRAIN: if (d_ack_o) d_req_i = 1'b0;
        default: begin
          if (d_req_i && !d_ack_o) begin
            d_req_i = 1'b1;
          end else if ((d_req_i && $urandom_range(1, 0) == 1) || (!d_req_i && $urandom_range(2, 0) == 0)) begin
            d_req_i = 1'b1;
            d_addr_i = rand_addr();
            d_we_i = 1'($urandom_range(1, 0));
            d_wdata_i = $urandom;
          end else begin
            d_req_i = 1'b0;
          end
        end
      endcase
    end
  end

  // Reference model: phase 0 = free, 1 = waiting on memory, 2 = ack cycle.
  int          ph = 0;
  bit          m_last = 1'b1;
  bit          m_port;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  bit          mon_en = 1'b0;
  bit          glog_en = 1'b0;
  bit          prev_req = 1'b0;
  bit          dut_grants[$];

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (glog_en && mem_req_o && !prev_req) dut_grants.push_back(mem_addr_o == d_hold_addr);
      prev_req = mem_req_o;
      if (rst_i) begin
        ph = 0;
        m_last = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
      end else begin
        case (ph)
          0: begin
            check("idle_busy", busy_o, 1'b0);
            check("idle_mem_req", mem_req_o, 1'b0);
            check("idle_mem_we", mem_we_o, 1'b0);
            check("idle_if_ack", if_ack_o, 1'b0);
            check("idle_d_ack", d_ack_o, 1'b0);
            if (if_req_i || d_req_i) begin
              if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
                m_port = ~m_last;
`else
                m_port = 1'b1;
`endif
              end else begin
                m_port = d_req_i;
              end
              m_addr  = m_port ? d_addr_i : if_addr_i;
              m_we    = m_port & d_we_i;
              m_wdata = d_wdata_i;
              m_last  = m_port;
              ph = 1;
            end
          end
          1: begin
            check("busy_busy", busy_o, 1'b1);
            check("busy_mem_req", mem_req_o, 1'b1);
            check("busy_mem_addr", mem_addr_o, m_addr);
            check("busy_mem_we", mem_we_o, m_we);
            if (m_we) check("busy_mem_wdata", mem_wdata_o, m_wdata);
            check("busy_if_ack", if_ack_o, 1'b0);
            check("busy_d_ack", d_ack_o, 1'b0);
            if (mem_ack_i) begin
              if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
              else m_rd = ref_mem[m_addr[5:2]];
              ph = 2;
            end
          end
          default: begin
            check("resp_busy", busy_o, 1'b1);
            check("resp_mem_req", mem_req_o, 1'b0);
            check("resp_mem_we", mem_we_o, 1'b0);
            check("resp_if_ack", if_ack_o, !m_port);
            check("resp_d_ack", d_ack_o, m_port);
            if (!m_port) exp_if_rdata = m_rd;
            else if (!m_we) exp_d_rdata = m_rd;
            ph = 0;
          end
        endcase
        check("if_rdata", if_rdata_o, exp_if_rdata);
        check("d_rdata", d_rdata_o, exp_d_rdata);
      end
    end
  end

  task automatic drain();
    int i;
    i = 0;
    while (i < 300 && (if_req_i || d_req_i || busy_o)) begin
      @(posedge clk_i); #2;
      i++;
    end
    check("drain_done", {31'd0, (if_req_i || d_req_i || busy_o)}, 32'd0);
  endtask

  initial begin
    bit late;
    rst_i = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;

    // Both ports held high from reset: grant order by the conflict rule.
    if_hold_addr = 32'h04;
    d_hold_addr  = 32'h08;
    d_hold_we    = 1'b0;
    dut_grants.delete();
    glog_en = 1'b1;
    if_mode = M_HOLD;
    d_mode  = M_HOLD;
    for (int i = 0; i < 300 && dut_grants.size() < 6; i++) @(posedge clk_i);
    #2;
    if_mode = M_DRAIN;
    d_mode  = M_DRAIN;
    glog_en = 1'b0;
    check("conflict_grant_count", {31'd0, dut_grants.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("conflict_grant%0d", i), dut_grants[i], (i % 2) == 1);
`else
      check($sformatf("conflict_grant%0d", i), dut_grants[i], 1'b1);
`endif
    end
    drain();

    // Random traffic with random latency and stray acks.
    stray_en = 1'b1;
    if_mode = M_RAND;
    d_mode  = M_RAND;
    repeat (3000) @(posedge clk_i);
    #2;
    if_mode = M_DRAIN;
    d_mode  = M_DRAIN;
    drain();

    // Reset during a D read; the late memory ack must be ignored.
    stray_en = 1'b0;
    lat_min = 6;
    lat_max = 6;
    d_hold_addr = 32'h0C;
    d_hold_we = 1'b0;
    d_mode = M_HOLD;
    for (int i = 0; i < 20 && !mem_req_o; i++) begin
      @(posedge clk_i); #2;
    end
    check("rst_test_started", mem_req_o, 1'b1);
    repeat (2) @(posedge clk_i);
    #2 d_mode = M_OFF;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    late = 1'b0;
    for (int i = 0; i < 20 && !late; i++) begin
      @(posedge clk_i); #2;
      if (mem_ack_i) late = 1'b1;
    end
    check("late_ack_arrived", late, 1'b1);
    @(posedge clk_i); #2;
    check("late_ack_d_ack", d_ack_o, 1'b0);
    check("late_ack_d_rdata", d_rdata_o, 32'h0);
    check("late_ack_busy", busy_o, 1'b0);
    repeat (3) @(posedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
